// File: rtl/layer_stream_sequencer.sv
// layer_stream_sequencer
//   Sequences one inference through the single-layer datapath. It takes
//   NUM_INPUTS words from the input stream and forwards each one to the
//   layer one cycle later. It then blocks the stream until the layer strobes
//   its result. The NUM_NEURONS results are held for word-by-word readout,
//   and intr stays high while any of them is unread.
//
// Ports
//   s_axi_aclk / s_axi_aresetn    clock, async active-low reset
//   soft_reset                    synchronous clear, same effect as reset
//   axis_in_data[_valid/_ready]   input stream (ready is registered)
//   x_valid / x_in                one-cycle word strobe to the layer
//   layer_o_valid / layer_x_out   layer result strobe and packed results
//   axi_rd_en / axi_rd_data       pop / current result word
//   results_left                  results not yet popped
//   intr                          high while results are pending
//   busy                          loading inputs or waiting on the layer
//   err_unexpected                sticky: layer result seen outside WAIT
module layer_stream_sequencer #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 30,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                              s_axi_aclk,
  input  logic                              s_axi_aresetn,
  input  logic                              soft_reset,
  input  logic [DATA_WIDTH-1:0]             axis_in_data,
  input  logic                              axis_in_data_valid,
  output logic                              axis_in_data_ready,
  output logic                              x_valid,
  output logic [DATA_WIDTH-1:0]             x_in,
  input  logic                              layer_o_valid,
  input  logic [NUM_NEURONS*DATA_WIDTH-1:0] layer_x_out,
  input  logic                              axi_rd_en,
  output logic [DATA_WIDTH-1:0]             axi_rd_data,
  output logic [CNT_WIDTH-1:0]              results_left,
  output logic                              intr,
  output logic                              busy,
  output logic                              err_unexpected
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_READOUT} state_t;

  localparam logic [CNT_WIDTH-1:0] LAST_IN = CNT_WIDTH'(NUM_INPUTS - 1);
  localparam logic [CNT_WIDTH-1:0] NN_CNT  = CNT_WIDTH'(NUM_NEURONS);

  state_t                          state, state_nxt;
  logic [CNT_WIDTH-1:0]            in_cnt;
  logic [NUM_NEURONS*DATA_WIDTH-1:0] hold;
  logic                            xfer, capture, pop;

  assign xfer    = axis_in_data_valid & axis_in_data_ready;
  assign capture = (state == S_WAIT) & layer_o_valid;
  assign pop     = (state == S_READOUT) & axi_rd_en;

  // next-state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (xfer) state_nxt = S_LOAD;
      S_LOAD:    if (xfer && in_cnt == LAST_IN) state_nxt = S_WAIT;
      S_WAIT:    if (layer_o_valid) state_nxt = S_READOUT;
      S_READOUT: if (axi_rd_en && results_left == CNT_WIDTH'(1)) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn)  state <= S_IDLE;
    else if (soft_reset) state <= S_IDLE;
    else                 state <= state_nxt;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      axis_in_data_ready <= 1'b0;
      x_valid            <= 1'b0;
      x_in               <= '0;
      in_cnt             <= '0;
      hold               <= '0;
      results_left       <= '0;
      intr               <= 1'b0;
      err_unexpected     <= 1'b0;
    end else if (soft_reset) begin
      axis_in_data_ready <= 1'b0;
      x_valid            <= 1'b0;
      x_in               <= '0;
      in_cnt             <= '0;
      hold               <= '0;
      results_left       <= '0;
      intr               <= 1'b0;
      err_unexpected     <= 1'b0;
    end else begin
      // Registered from next-state so the last accepted word drops ready
      // on the very next cycle, with no extra beat slipping through.
      axis_in_data_ready <= (state_nxt == S_IDLE) || (state_nxt == S_LOAD);
      x_valid            <= xfer;
      if (xfer) begin
        x_in   <= axis_in_data;
        in_cnt <= (state_nxt == S_WAIT) ? '0 : in_cnt + CNT_WIDTH'(1);
      end
      // Capture has priority; a pop can only happen in READOUT anyway.
      if (capture) begin
        hold         <= layer_x_out;
        results_left <= NN_CNT;
        intr         <= 1'b1;
      end else if (pop) begin
        hold         <= hold >> DATA_WIDTH;
        results_left <= results_left - CNT_WIDTH'(1);
        if (results_left == CNT_WIDTH'(1)) intr <= 1'b0;
      end
      if (layer_o_valid && state != S_WAIT) err_unexpected <= 1'b1;
    end
  end

  assign axi_rd_data = (state == S_READOUT) ? hold[DATA_WIDTH-1:0] : '0;
  assign busy        = (state == S_LOAD) || (state == S_WAIT);

endmodule

// File: tb/tb_layer_stream_sequencer.sv
module tb_layer_stream_sequencer;
  localparam int DW = 16, NI = 4, NN = 3, CW = 16;

  logic          clk = 1'b0, rst_n = 1'b1, soft_reset = 1'b0;
  logic [DW-1:0] data = '0;
  logic          valid = 1'b0, lov = 1'b0, rd_en = 1'b0;
  logic [NN*DW-1:0] xout = '0;
  logic          ready, x_valid, intr, busy, err;
  logic [DW-1:0] x_in, rd_data;
  logic [CW-1:0] results_left;

  layer_stream_sequencer #(.DATA_WIDTH(DW), .NUM_INPUTS(NI), .NUM_NEURONS(NN), .CNT_WIDTH(CW)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .soft_reset(soft_reset),
    .axis_in_data(data), .axis_in_data_valid(valid), .axis_in_data_ready(ready),
    .x_valid(x_valid), .x_in(x_in),
    .layer_o_valid(lov), .layer_x_out(xout),
    .axi_rd_en(rd_en), .axi_rd_data(rd_data), .results_left(results_left),
    .intr(intr), .busy(busy), .err_unexpected(err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: counts words accepted into the current inference and
  // keeps the unread results as a queue; everything else follows from that.
  int            m_acc = 0;
  logic [DW-1:0] m_res[$];
  logic [DW-1:0] m_xq[$];
  logic [DW-1:0] m_xin = '0;
  bit            m_ready = 0, m_xv = 0, m_err = 0;
  bit            m_waiting, m_take;
  int            m_pend;

  task automatic model_clear();
    m_acc = 0; m_res.delete(); m_xq.delete();
    m_xin = '0; m_ready = 0; m_xv = 0; m_err = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear();
    else if (soft_reset) model_clear();
    else begin
      m_waiting = (m_acc == NI);
      m_pend    = m_res.size();
      m_take    = valid && m_ready;
      m_xv      = m_take;
      if (m_take) begin
        m_xq.push_back(data);
        m_xin = data;
        m_acc++;
      end
      if (lov) begin
        if (m_waiting) begin
          for (int i = 0; i < NN; i++) m_res.push_back(xout[i*DW +: DW]);
          m_acc = 0;
        end else m_err = 1;
      end
      if (rd_en && m_pend > 0) void'(m_res.pop_front());
      m_ready = (m_acc < NI) && (m_res.size() == 0);
    end
  end

  // Monitor: compares every output against the model away from the edge.
  always @(negedge clk) begin
    chk("ready", 64'(ready), 64'(m_ready));
    chk("x_valid", 64'(x_valid), 64'(m_xv));
    if (m_xv && m_xq.size() > 0) chk("x_in", 64'(x_in), 64'(m_xq.pop_front()));
    else                         chk("x_in_hold", 64'(x_in), 64'(m_xin));
    chk("intr", 64'(intr), 64'(m_res.size() > 0));
    chk("results_left", 64'(results_left), 64'(m_res.size()));
    chk("rd_data", 64'(rd_data), m_res.size() > 0 ? 64'(m_res[0]) : 64'd0);
    chk("busy", 64'(busy), 64'(m_acc > 0));
    chk("err_unexpected", 64'(err), 64'(m_err));
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Holds the word on the stream until the model says it was taken.
  task automatic send(input logic [DW-1:0] w);
    int n = 0;
    valid = 1'b1; data = w;
    do begin tick(); n++; end while (!m_xv && n < 20);
    total++;
    if (!m_xv) begin bad++; $display("FAIL send_timeout word=%0h", w); end
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) begin
      rd_en = 1'b1; tick(); rd_en = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic infer();
    for (int i = 0; i < NI; i++) send(DW'($urandom));
    valid = 1'b0;
    repeat (2) tick();
    lov = 1'b1; xout = {16'($urandom), 16'($urandom), 16'($urandom)};
    tick(); lov = 1'b0;
    pops(NN);
    tick();
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    // back-to-back stream of four words
    for (int i = 0; i < NI; i++) send(DW'(16'h0011 + i));
    // sender keeps offering while the block waits on the layer
    data = 16'h00FF;
    repeat (5) tick();
    valid = 1'b0;
    lov = 1'b1; xout = {16'h0003, 16'h0002, 16'h0001};
    tick(); lov = 1'b0;
    pops(NN);
    tick();
    infer();
    // stray result strobe in IDLE, then clear it
    lov = 1'b1; tick(); lov = 1'b0; tick();
    soft_reset = 1'b1; tick(); soft_reset = 1'b0; tick();
    // abandon a partial inference
    send(16'hA001); send(16'hA002); valid = 1'b0;
    soft_reset = 1'b1; tick(); soft_reset = 1'b0;
    infer();
    // async reset in the middle of readout
    for (int i = 0; i < NI; i++) send(DW'(16'hB000 + i));
    valid = 1'b0;
    lov = 1'b1; xout = {16'hC003, 16'hC002, 16'hC001}; tick(); lov = 1'b0;
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    rst_n = 1'b0; #1;
    chk("async_intr", 64'(intr), 64'd0);
    chk("async_rd_data", 64'(rd_data), 64'd0);
    chk("async_ready", 64'(ready), 64'd0);
    chk("async_results_left", 64'(results_left), 64'd0);
    tick(); rst_n = 1'b1; tick();
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if (!(valid && !m_xv)) begin
        valid = 1'($urandom_range(0, 1));
        data  = DW'($urandom);
      end
      lov        = ($urandom_range(0, 9) == 0);
      xout       = {16'($urandom), 16'($urandom), 16'($urandom)};
      rd_en      = ($urandom_range(0, 2) == 0);
      soft_reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0; #1; tick(); rst_n = 1'b1;
      end
      tick();
    end
    valid = 1'b0; lov = 1'b0; rd_en = 1'b0; soft_reset = 1'b0;
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
